// File: rtl/coreaxi4dmacontroller_rd_pkg.sv
// Shared encodings for the DMA read transaction controller: FSM states,
// source operation types, error codes and the AXI burst type it issues.
package coreaxi4dmacontroller_rd_pkg;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_ISSUE     = 6'b000010,
        ST_WAIT_DATA = 6'b000100,
        ST_DONE      = 6'b001000,
        ST_ERROR     = 6'b010000,
        ST_ZERO      = 6'b100000
    } rd_state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_INCR  = 2'b01;
    localparam logic [1:0] OP_FIXED = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_RESP = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_OP   = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/coreaxi4dmacontroller_rd_beat_chk.sv
// Counts returned read beats and flags response and length errors. The flag
// outputs already include the beat presented this cycle, so the controller
// can decide the final status on the last beat itself.
module coreaxi4dmacontroller_rd_beat_chk
    import coreaxi4dmacontroller_rd_pkg::*;
#(
    parameter int NUM_OF_BEATS_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          rd_beat,
    input  logic                          rd_last,
    input  logic                          rd_resp_err,
    input  logic [NUM_OF_BEATS_WIDTH-1:0] exp_len,
    output logic                          last_seen,
    output logic                          resp_err,
    output logic                          len_err
);

    localparam int CW = NUM_OF_BEATS_WIDTH + 1;

    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] cnt_next;
    logic          resp_err_q;
    logic          len_err_q;
    logic          beat;
    logic          wrap;
    logic          len_mismatch;

    always_comb begin
        beat         = enable & rd_beat;
        cnt_next     = beat_cnt + CW'(1);
        // A wrap without the last beat can never match, so it is a length error.
        wrap         = beat && (beat_cnt == {CW{1'b1}});
        len_mismatch = beat && rd_last && (cnt_next != ({1'b0, exp_len} + CW'(1)));
        last_seen    = beat & rd_last;
        resp_err     = resp_err_q | (beat & rd_resp_err);
        len_err      = len_err_q | len_mismatch | wrap;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            beat_cnt   <= '0;
            resp_err_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else if (beat) begin
            beat_cnt   <= cnt_next;
            resp_err_q <= resp_err;
            len_err_q  <= len_err;
        end
    end

endmodule

// File: rtl/coreaxi4dmacontroller_rd_tran_ctrl.sv
// Read transaction controller: turns one dispatcher request into one AXI4
// read burst command, checks the returned beats and holds the final status.
module coreaxi4dmacontroller_rd_tran_ctrl
    import coreaxi4dmacontroller_rd_pkg::*;
#(
    parameter int NUM_PRI_LVLS        = 4,
    parameter int MAX_TRAN_SIZE_WIDTH = 23,
    parameter int NUM_OF_BEATS_WIDTH  = 8,
    parameter int PRI_0_NUM_OF_BEATS  = 255,
    parameter int PRI_1_NUM_OF_BEATS  = 127,
    parameter int PRI_2_NUM_OF_BEATS  = 63,
    parameter int PRI_3_NUM_OF_BEATS  = 15,
    parameter int DSCR_NUM_OF_BEATS   = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           rdTranReq,
    input  logic                           dscrptrFetch,
    input  logic [1:0]                     srcOpType,
    input  logic [31:0]                    srcAddr,
    input  logic [MAX_TRAN_SIZE_WIDTH-1:0] numOfBytes,
    input  logic [NUM_PRI_LVLS-1:0]        priLvl,
    input  logic [2:0]                     srcSize,
    input  logic                           rdTranAccept,
    input  logic                           rdBeat,
    input  logic                           rdLast,
    input  logic [1:0]                     rdResp,
    input  logic                           rdTranAck,
    output logic                           rdTranValid,
    output logic [31:0]                    rdTranAddr,
    output logic [1:0]                     rdTranBurst,
    output logic [2:0]                     rdTranSize,
    output logic [NUM_OF_BEATS_WIDTH-1:0]  rdTranLen,
    output logic [MAX_TRAN_SIZE_WIDTH-1:0] rdTranBytes,
    output logic                           rdTranDscrptr,
    output logic                           rdTranDone,
    output logic                           rdTranError,
    output logic [1:0]                     rdTranErrCode,
    output logic                           rdTranZeroOp,
    output logic [5:0]                     fsm_state
);

    rd_state_t                     state;
    logic [NUM_OF_BEATS_WIDTH-1:0] len_sel;
    logic                          last_seen;
    logic                          resp_err;
    logic                          len_err;
    logic                          unused_resp_bit;

    assign unused_resp_bit = rdResp[0];
    assign fsm_state       = state;

    // Zero or multi-hot priority falls through to the priority-3 length.
    always_comb begin
        len_sel = NUM_OF_BEATS_WIDTH'(PRI_3_NUM_OF_BEATS);
        if (dscrptrFetch)
            len_sel = NUM_OF_BEATS_WIDTH'(DSCR_NUM_OF_BEATS);
        else if (priLvl == NUM_PRI_LVLS'(1))
            len_sel = NUM_OF_BEATS_WIDTH'(PRI_0_NUM_OF_BEATS);
        else if (priLvl == NUM_PRI_LVLS'(2))
            len_sel = NUM_OF_BEATS_WIDTH'(PRI_1_NUM_OF_BEATS);
        else if (priLvl == NUM_PRI_LVLS'(4))
            len_sel = NUM_OF_BEATS_WIDTH'(PRI_2_NUM_OF_BEATS);
    end

    coreaxi4dmacontroller_rd_beat_chk #(
        .NUM_OF_BEATS_WIDTH(NUM_OF_BEATS_WIDTH)
    ) u_beat_chk (
        .clock      (clock),
        .reset      (reset),
        .clear      (state == ST_IDLE),
        .enable     (state == ST_WAIT_DATA),
        .rd_beat    (rdBeat),
        .rd_last    (rdLast),
        .rd_resp_err(rdResp[1]),
        .exp_len    (rdTranLen),
        .last_seen  (last_seen),
        .resp_err   (resp_err),
        .len_err    (len_err)
    );

    // Command handshake: the command transfers on the cycle rdTranValid and
    // rdTranAccept are both high; until then the payload is held unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            rdTranValid   <= 1'b0;
            rdTranAddr    <= '0;
            rdTranBurst   <= '0;
            rdTranSize    <= '0;
            rdTranLen     <= '0;
            rdTranBytes   <= '0;
            rdTranDscrptr <= 1'b0;
            rdTranDone    <= 1'b0;
            rdTranError   <= 1'b0;
            rdTranErrCode <= ERR_NONE;
            rdTranZeroOp  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rdTranReq) begin
                        case (srcOpType)
                            OP_NOP: begin
                                state        <= ST_ZERO;
                                rdTranZeroOp <= 1'b1;
                            end
                            OP_RSVD: begin
                                state         <= ST_ERROR;
                                rdTranError   <= 1'b1;
                                rdTranErrCode <= ERR_OP;
                            end
                            OP_INCR, OP_FIXED: begin
                                state         <= ST_ISSUE;
                                rdTranValid   <= 1'b1;
                                rdTranAddr    <= srcAddr;
                                rdTranBurst   <= dscrptrFetch ? BURST_INCR : srcOpType;
                                rdTranSize    <= srcSize;
                                rdTranLen     <= len_sel;
                                rdTranBytes   <= numOfBytes;
                                rdTranDscrptr <= dscrptrFetch;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (rdTranAccept) begin
                        state       <= ST_WAIT_DATA;
                        rdTranValid <= 1'b0;
                    end
                end
                ST_WAIT_DATA: begin
                    if (last_seen) begin
                        if (resp_err) begin
                            state         <= ST_ERROR;
                            rdTranError   <= 1'b1;
                            rdTranErrCode <= ERR_RESP;
                        end else if (len_err) begin
                            state         <= ST_ERROR;
                            rdTranError   <= 1'b1;
                            rdTranErrCode <= ERR_LEN;
                        end else begin
                            state      <= ST_DONE;
                            rdTranDone <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rdTranAck && rdTranDone) begin
                        state      <= ST_IDLE;
                        rdTranDone <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (rdTranAck && rdTranError) begin
                        state         <= ST_IDLE;
                        rdTranError   <= 1'b0;
                        rdTranErrCode <= ERR_NONE;
                    end
                end
                ST_ZERO: begin
                    if (rdTranAck && rdTranZeroOp) begin
                        state        <= ST_IDLE;
                        rdTranZeroOp <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coreaxi4dmacontroller_rd_tran_ctrl.sv
// Directed bench for the DMA read transaction controller: a vector table of
// single requests plus hand-written multi-cycle sequences.
module tb_coreaxi4dmacontroller_rd_tran_ctrl;
    import coreaxi4dmacontroller_rd_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        rdTranReq;
    logic        dscrptrFetch;
    logic [1:0]  srcOpType;
    logic [31:0] srcAddr;
    logic [22:0] numOfBytes;
    logic [3:0]  priLvl;
    logic [2:0]  srcSize;
    logic        rdTranAccept;
    logic        rdBeat;
    logic        rdLast;
    logic [1:0]  rdResp;
    logic        rdTranAck;
    logic        rdTranValid;
    logic [31:0] rdTranAddr;
    logic [1:0]  rdTranBurst;
    logic [2:0]  rdTranSize;
    logic [7:0]  rdTranLen;
    logic [22:0] rdTranBytes;
    logic        rdTranDscrptr;
    logic        rdTranDone;
    logic        rdTranError;
    logic [1:0]  rdTranErrCode;
    logic        rdTranZeroOp;
    logic [5:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    coreaxi4dmacontroller_rd_tran_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .rdTranReq    (rdTranReq),
        .dscrptrFetch (dscrptrFetch),
        .srcOpType    (srcOpType),
        .srcAddr      (srcAddr),
        .numOfBytes   (numOfBytes),
        .priLvl       (priLvl),
        .srcSize      (srcSize),
        .rdTranAccept (rdTranAccept),
        .rdBeat       (rdBeat),
        .rdLast       (rdLast),
        .rdResp       (rdResp),
        .rdTranAck    (rdTranAck),
        .rdTranValid  (rdTranValid),
        .rdTranAddr   (rdTranAddr),
        .rdTranBurst  (rdTranBurst),
        .rdTranSize   (rdTranSize),
        .rdTranLen    (rdTranLen),
        .rdTranBytes  (rdTranBytes),
        .rdTranDscrptr(rdTranDscrptr),
        .rdTranDone   (rdTranDone),
        .rdTranError  (rdTranError),
        .rdTranErrCode(rdTranErrCode),
        .rdTranZeroOp (rdTranZeroOp),
        .fsm_state    (fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        dscr;
        logic [1:0]  op;
        logic [3:0]  pri;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [22:0] bytes;
        logic        exp_valid;
        logic [7:0]  exp_len;
        logic [1:0]  exp_burst;
        logic        exp_zero;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
        end
    endtask

    task automatic set_req(input logic dscr, input logic [1:0] op, input logic [3:0] pri,
                           input logic [31:0] addr, input logic [2:0] size, input logic [22:0] bytes);
        dscrptrFetch = dscr;
        srcOpType    = op;
        priLvl       = pri;
        srcAddr      = addr;
        srcSize      = size;
        numOfBytes   = bytes;
    endtask

    task automatic send_beats(input int n, input bit with_last, input int err_idx);
        for (int i = 0; i < n; i++) begin
            rdBeat = 1'b1;
            rdLast = with_last && (i == n - 1);
            rdResp = (i == err_idx) ? 2'b10 : 2'b00;
            step();
        end
        rdBeat = 1'b0;
        rdLast = 1'b0;
        rdResp = 2'b00;
    endtask

    task automatic accept_now();
        rdTranAccept = 1'b1;
        step();
        rdTranAccept = 1'b0;
    endtask

    task automatic ack_and_check(input string tag);
        rdTranAck = 1'b1;
        step();
        rdTranAck = 1'b0;
        chk({tag, "_ack_done"}, rdTranDone, 0);
        chk({tag, "_ack_err"}, rdTranError, 0);
        chk({tag, "_ack_zero"}, rdTranZeroOp, 0);
        chk({tag, "_ack_code"}, rdTranErrCode, 0);
        chk({tag, "_ack_state"}, fsm_state, ST_IDLE);
    endtask

    initial begin
        reset = 1'b1;
        rdTranReq = 1'b0;
        rdTranAccept = 1'b0;
        rdBeat = 1'b0;
        rdLast = 1'b0;
        rdResp = 2'b00;
        rdTranAck = 1'b0;
        set_req(1'b0, 2'b00, 4'b0000, 32'h0, 3'd0, 23'd0);

        //            dscr  op     pri      addr          size bytes  vld len   burst zero err code
        vecs[0] = '{1'b0, 2'b01, 4'b0001, 32'h1000_0040, 3'd3, 23'd2048, 1'b1, 8'd255, 2'b01, 1'b0, 1'b0, 2'b00};
        vecs[1] = '{1'b0, 2'b01, 4'b0010, 32'h2000_0000, 3'd2, 23'd512,  1'b1, 8'd127, 2'b01, 1'b0, 1'b0, 2'b00};
        vecs[2] = '{1'b0, 2'b10, 4'b0100, 32'h3000_0100, 3'd1, 23'd128,  1'b1, 8'd63,  2'b10, 1'b0, 1'b0, 2'b00};
        vecs[3] = '{1'b0, 2'b01, 4'b1000, 32'h0000_0800, 3'd0, 23'd16,   1'b1, 8'd15,  2'b01, 1'b0, 1'b0, 2'b00};
        vecs[4] = '{1'b0, 2'b01, 4'b0000, 32'h0000_1000, 3'd2, 23'd64,   1'b1, 8'd15,  2'b01, 1'b0, 1'b0, 2'b00};
        vecs[5] = '{1'b0, 2'b10, 4'b0011, 32'hABCD_0000, 3'd2, 23'd64,   1'b1, 8'd15,  2'b10, 1'b0, 1'b0, 2'b00};
        vecs[6] = '{1'b1, 2'b10, 4'b0001, 32'h0000_4000, 3'd3, 23'd32,   1'b1, 8'd3,   2'b01, 1'b0, 1'b0, 2'b00};
        vecs[7] = '{1'b0, 2'b00, 4'b0001, 32'h5000_0000, 3'd2, 23'd0,    1'b0, 8'd0,   2'b00, 1'b1, 1'b0, 2'b00};
        vecs[8] = '{1'b0, 2'b11, 4'b0010, 32'h6000_0000, 3'd2, 23'd8,    1'b0, 8'd0,   2'b00, 1'b0, 1'b1, 2'b11};
        vecs[9] = '{1'b1, 2'b00, 4'b0100, 32'h7000_0000, 3'd3, 23'd32,   1'b0, 8'd0,   2'b00, 1'b1, 1'b0, 2'b00};

        // Reset state
        step();
        step();
        chk("rst_valid", rdTranValid, 0);
        chk("rst_done", rdTranDone, 0);
        chk("rst_err", rdTranError, 0);
        chk("rst_zero", rdTranZeroOp, 0);
        chk("rst_addr", rdTranAddr, 0);
        chk("rst_len", rdTranLen, 0);
        chk("rst_state", fsm_state, ST_IDLE);
        reset = 1'b0;
        step();

        // Table: one request per vector, run to its status and acknowledge
        for (int v = 0; v < 10; v++) begin
            set_req(vecs[v].dscr, vecs[v].op, vecs[v].pri, vecs[v].addr, vecs[v].size, vecs[v].bytes);
            rdTranReq = 1'b1;
            step();
            rdTranReq = 1'b0;
            chk($sformatf("v%0d_valid", v), rdTranValid, vecs[v].exp_valid);
            chk($sformatf("v%0d_zero", v), rdTranZeroOp, vecs[v].exp_zero);
            chk($sformatf("v%0d_err", v), rdTranError, vecs[v].exp_err);
            chk($sformatf("v%0d_code", v), rdTranErrCode, vecs[v].exp_code);
            if (vecs[v].exp_valid) begin
                chk($sformatf("v%0d_len", v), rdTranLen, vecs[v].exp_len);
                chk($sformatf("v%0d_burst", v), rdTranBurst, vecs[v].exp_burst);
                chk($sformatf("v%0d_addr", v), rdTranAddr, vecs[v].addr);
                chk($sformatf("v%0d_size", v), rdTranSize, vecs[v].size);
                chk($sformatf("v%0d_bytes", v), rdTranBytes, vecs[v].bytes);
                chk($sformatf("v%0d_dscr", v), rdTranDscrptr, vecs[v].dscr);
                accept_now();
                chk($sformatf("v%0d_valid_drop", v), rdTranValid, 0);
                send_beats(int'(vecs[v].exp_len) + 1, 1'b1, -1);
                chk($sformatf("v%0d_done", v), rdTranDone, 1);
                chk($sformatf("v%0d_done_err", v), rdTranError, 0);
            end
            step();
            chk($sformatf("v%0d_hold_valid", v), rdTranValid, 0);
            chk($sformatf("v%0d_hold_status", v),
                {rdTranDone, rdTranError, rdTranZeroOp},
                {vecs[v].exp_valid, vecs[v].exp_err, vecs[v].exp_zero});
            ack_and_check($sformatf("v%0d", v));
        end

        // Accept stalled three cycles: payload must hold steady
        set_req(1'b0, 2'b01, 4'b0001, 32'h1000_0040, 3'd2, 23'd1024);
        rdTranReq = 1'b1;
        step();
        rdTranReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_valid", i), rdTranValid, 1);
            chk($sformatf("stall%0d_addr", i), rdTranAddr, 32'h1000_0040);
            chk($sformatf("stall%0d_len", i), rdTranLen, 255);
            chk($sformatf("stall%0d_burst", i), rdTranBurst, 2'b01);
            srcAddr = 32'hDEAD_BEEF;
            priLvl  = 4'b1000;
            step();
        end
        chk("stall_end_valid", rdTranValid, 1);
        accept_now();
        chk("stall_after_accept_valid", rdTranValid, 0);
        send_beats(255, 1'b0, -1);
        chk("stall_no_early_done", rdTranDone, 0);
        send_beats(1, 1'b1, -1);
        chk("stall_done", rdTranDone, 1);
        step();
        step();
        chk("stall_done_held", rdTranDone, 1);
        ack_and_check("stall");

        // Descriptor fetch with a response error on beat 2
        set_req(1'b1, 2'b01, 4'b0100, 32'h0000_8000, 3'd3, 23'd32);
        rdTranReq = 1'b1;
        step();
        rdTranReq = 1'b0;
        chk("dscr_len", rdTranLen, 3);
        chk("dscr_flag", rdTranDscrptr, 1);
        accept_now();
        send_beats(4, 1'b1, 2);
        chk("resp_err", rdTranError, 1);
        chk("resp_code", rdTranErrCode, ERR_RESP);
        chk("resp_done", rdTranDone, 0);
        ack_and_check("resp");

        // Short burst: 100 beats where 128 are expected
        set_req(1'b0, 2'b01, 4'b0010, 32'h0000_9000, 3'd2, 23'd512);
        rdTranReq = 1'b1;
        step();
        rdTranReq = 1'b0;
        chk("len_len", rdTranLen, 127);
        accept_now();
        send_beats(100, 1'b1, -1);
        chk("len_err", rdTranError, 1);
        chk("len_code", rdTranErrCode, ERR_LEN);
        ack_and_check("len");

        // Reset during data phase after 10 beats, then a clean request
        set_req(1'b0, 2'b01, 4'b1000, 32'h0000_A000, 3'd2, 23'd64);
        rdTranReq = 1'b1;
        step();
        rdTranReq = 1'b0;
        accept_now();
        send_beats(10, 1'b0, -1);
        chk("mid_state_wait", fsm_state, ST_WAIT_DATA);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_state", fsm_state, ST_IDLE);
        chk("mid_rst_outs",
            {rdTranValid, rdTranDone, rdTranError, rdTranZeroOp, rdTranErrCode, rdTranLen},
            0);
        chk("mid_rst_addr", rdTranAddr, 0);
        rdTranReq = 1'b1;
        step();
        rdTranReq = 1'b0;
        chk("post_rst_valid", rdTranValid, 1);
        accept_now();
        send_beats(16, 1'b1, -1);
        chk("post_rst_done", rdTranDone, 1);
        chk("post_rst_err", rdTranError, 0);
        ack_and_check("post_rst");

        // Ack ignored in data phase; request and ack held through DONE
        set_req(1'b0, 2'b01, 4'b1000, 32'h0000_B000, 3'd2, 23'd64);
        rdTranReq = 1'b1;
        step();
        chk("b2b_valid1", rdTranValid, 1);
        accept_now();
        send_beats(8, 1'b0, -1);
        rdTranAck = 1'b1;
        step();
        rdTranAck = 1'b0;
        chk("b2b_ack_in_wait_state", fsm_state, ST_WAIT_DATA);
        chk("b2b_ack_in_wait_status", {rdTranDone, rdTranError}, 0);
        rdTranAck = 1'b1;
        send_beats(8, 1'b1, -1);
        chk("b2b_done", rdTranDone, 1);
        step();
        chk("b2b_back_idle", fsm_state, ST_IDLE);
        chk("b2b_idle_done", rdTranDone, 0);
        chk("b2b_idle_valid", rdTranValid, 0);
        step();
        chk("b2b_valid2", rdTranValid, 1);
        chk("b2b_state2", fsm_state, ST_ISSUE);
        rdTranReq = 1'b0;
        rdTranAck = 1'b0;
        accept_now();
        send_beats(16, 1'b1, -1);
        chk("b2b_done2", rdTranDone, 1);
        ack_and_check("b2b2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coreaxi4dmacontroller_rd_tran_ctrl.md
Name: coreaxi4dmacontroller_rd_tran_ctrl

Overview:
- Read-side transaction controller of the AXI4 DMA; counterpart of the write transaction controller.
- Takes a read request from the channel dispatcher, either a data-source read or a descriptor fetch.
- Issues one AXI4 read burst command to the AXI4 master read-channel controller and monitors returned beats for response errors and length errors.
- Reports done, error or zero-op to the dispatcher and holds that status until acknowledged.

Parameters:
- NUM_PRI_LVLS, 4: number of one-hot priority levels on priLvl.
- MAX_TRAN_SIZE_WIDTH, 23: width of the byte-count field.
- NUM_OF_BEATS_WIDTH, 8: AXI ARLEN width.
- PRI_0_NUM_OF_BEATS, 255: ARLEN for priority 0.
- PRI_1_NUM_OF_BEATS, 127: ARLEN for priority 1.
- PRI_2_NUM_OF_BEATS, 63: ARLEN for priority 2.
- PRI_3_NUM_OF_BEATS, 15: ARLEN for priority 3 and for any non-one-hot priLvl.
- DSCR_NUM_OF_BEATS, 3: ARLEN for a descriptor fetch.

Ports:
- clock  in  1  — sole clock.
- reset  in  1  — synchronous, active-high reset.
- rdTranReq  in  1  — level request; sampled only in IDLE.
- dscrptrFetch  in  1  — 1 = descriptor fetch, 0 = data read.
- srcOpType  in  2  — 00 no-op, 01 INCR, 10 FIXED, 11 reserved.
- srcAddr  in  32  — read start address.
- numOfBytes  in  MAX_TRAN_SIZE_WIDTH  — byte count, passed through.
- priLvl  in  NUM_PRI_LVLS  — one-hot priority of the requesting channel.
- srcSize  in  3  — AXI ARSIZE.
- rdTranAccept  in  1  — ready from the read-channel controller.
- rdBeat  in  1  — one read data beat received.
- rdLast  in  1  — qualifies rdBeat as the last beat.
- rdResp  in  2  — RRESP of the beat; bit 1 set means error.
- rdTranAck  in  1  — dispatcher acknowledge of done, error or zero-op.
- rdTranValid  out  1  — command valid.
- rdTranAddr  out  32  — command address.
- rdTranBurst  out  2  — command ARBURST.
- rdTranSize  out  3  — command ARSIZE.
- rdTranLen  out  NUM_OF_BEATS_WIDTH  — command ARLEN.
- rdTranBytes  out  MAX_TRAN_SIZE_WIDTH  — command byte count.
- rdTranDscrptr  out  1  — command is a descriptor fetch.
- rdTranDone  out  1  — transaction completed without error.
- rdTranError  out  1  — transaction ended in error.
- rdTranErrCode  out  2  — 01 response error, 10 length mismatch, 11 reserved op type.
- rdTranZeroOp  out  1  — no-op request completed.

Behaviour:
- All outputs are registered.
- On reset: state = IDLE, every output = 0, beat counter = 0, error flags = 0.
- reset asserted mid-operation aborts immediately; no done or error is reported.

State machine (one-hot: IDLE, ISSUE, WAIT_DATA, DONE, ERROR, ZERO):
- IDLE with rdTranReq = 1:
  - srcOpType 00 -> ZERO.
  - srcOpType 11 -> ERROR with code 11; no command is issued.
  - otherwise -> ISSUE, latching the payload.
- IDLE with rdTranReq = 0: remain in IDLE.
- Command payload latched on leaving IDLE:
  - rdTranAddr = srcAddr.
  - rdTranBurst = srcOpType, except a descriptor fetch is forced to 01.
  - rdTranSize = srcSize.
  - rdTranBytes = numOfBytes.
  - rdTranDscrptr = dscrptrFetch.
- rdTranLen selection:
  - descriptor fetch: DSCR_NUM_OF_BEATS.
  - otherwise priLvl bit k alone set selects PRI_k_NUM_OF_BEATS.
  - zero or multi-hot priLvl selects PRI_3_NUM_OF_BEATS.
- ISSUE:
  - rdTranValid = 1; payload held stable until rdTranAccept is sampled high.
  - On that cycle go to WAIT_DATA; rdTranValid = 0 from the next cycle.
- WAIT_DATA:
  - Each rdBeat increments a NUM_OF_BEATS_WIDTH+1-bit counter.
  - rdResp[1] on any beat sets a sticky respErr flag.
  - On rdBeat with rdLast: the beat is counted first; if total beats != rdTranLen+1, lenErr is set.
  - Then go to ERROR if either flag is set, else DONE.
  - respErr takes priority over lenErr in the code: 01 before 10.
  - A counter overflow without rdLast sets lenErr and continues waiting.
- DONE / ERROR / ZERO:
  - The corresponding output, plus rdTranErrCode in ERROR, is held high.
  - They stay held until rdTranAck is sampled while the output is already high.
  - Next cycle: outputs return to 0 and state to IDLE; counter and flags are cleared.

Latency:
- rdTranReq sampled at cycle N -> rdTranValid (or status) high at N+1.
- Last beat at cycle M -> status high at M+1.

Ignored inputs and boundary cases:
- rdTranReq outside IDLE.
- rdTranAck outside DONE/ERROR/ZERO.
- rdBeat outside WAIT_DATA.
- rdTranAccept outside ISSUE.
- The earliest new request is the first cycle back in IDLE.

Decomposition:
- Package coreaxi4dmacontroller_rd_pkg holds:
  - state one-hot localparams;
  - op-type codes 00/01/10/11;
  - error codes;
  - the AXI burst encoding.
- Sub-module coreaxi4dmacontroller_rd_beat_chk holds the beat counter, respErr and lenErr logic.
  - Inputs: clear, enable, rdBeat, rdLast, rdResp, expected length.
  - Outputs: lastSeen, respErr, lenErr.

Test Plan:
1. Data read with priLvl=0001, srcOpType=01, srcAddr=0x1000_0040:
   - rdTranValid high 1 cycle after req, with rdTranLen=255 and burst 01.
   - Hold rdTranAccept low 3 cycles -> payload stable throughout.
   - Return 256 beats, last with rdLast -> rdTranDone 1 cycle later, held until rdTranAck.
2. Descriptor fetch with priLvl=0100:
   - rdTranLen=3 and rdTranDscrptr=1.
   - Return 4 beats, rdResp=10 on beat 2 -> rdTranError with code 01.
3. priLvl=0010, 100 beats, then rdLast -> rdTranError with code 10 (expected 128 beats).
4. Invalid inputs:
   - srcOpType=00 -> rdTranZeroOp high next cycle; rdTranValid never asserted.
   - srcOpType=11 -> rdTranError with code 11; rdTranValid never asserted.
5. Assert reset during WAIT_DATA after 10 beats:
   - All outputs 0 next cycle; state is IDLE.
   - The following request is issued normally with the counter starting from 0.
6. Status and acknowledge timing:
   - rdTranReq held high through DONE with rdTranAck held high -> a second command is issued 1 cycle after return to IDLE.
   - rdTranAck pulsed during WAIT_DATA has no effect.
